// File: rtl/car_sensor_driver.sv
// car_sensor_driver: transmit side of the car-park gate sensor interface.
// Plays out the outer/inner sensor waveform of one car passing the gate
// (entry or exit) on command, and keeps a saturating local occupancy count.
// Optional feature macro: CAR_ABORT_EN (abort input cuts a sequence short).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high, sensors 00
// P1    | first pattern (entry 10, exit 01), HOLD_CYCLES long
// P2    | both sensors covered (11), HOLD_CYCLES long
// P3    | last pattern (entry 01, exit 10), HOLD_CYCLES long
// GAP   | sensors clear (00) for GAP_CYCLES before completion
module car_sensor_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int OCC_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_dir,
  output logic                 cmd_ready,
  input  logic                 abort,
  output logic                 sensor_a,
  output logic                 sensor_b,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [OCC_WIDTH-1:0] occupancy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [7:0]           HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]           GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [OCC_WIDTH-1:0] OCC_MAX   = '1;
  localparam logic [OCC_WIDTH-1:0] OCC_ZERO  = '0;
  localparam logic [OCC_WIDTH-1:0] OCC_ONE   = {{(OCC_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic                 dir, dir_nxt;
  logic                 abort_flag, abort_flag_nxt;
  logic                 abort_req;
  logic                 a_nxt, b_nxt, done_nxt, aborted_nxt;
  logic [OCC_WIDTH-1:0] occ_nxt;

`ifdef CAR_ABORT_EN
  assign abort_req = abort;
`else
  // abort has no effect in this build; the AND keeps the port read.
  assign abort_req = abort & 1'b0;
`endif

  // Next state, down-counter reload, completion pulses and output patterns.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    dir_nxt        = dir;
    abort_flag_nxt = abort_flag;
    done_nxt       = 1'b0;
    aborted_nxt    = 1'b0;
    occ_nxt        = occupancy;
    a_nxt          = 1'b0;
    b_nxt          = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt      = S_P1;
          cnt_nxt        = HOLD_LOAD;
          dir_nxt        = cmd_dir;
          abort_flag_nxt = 1'b0;
        end
      end
      S_P1, S_P2, S_P3: begin
        if (abort_req) begin
          state_nxt      = S_GAP;
          cnt_nxt        = GAP_LOAD;
          abort_flag_nxt = 1'b1;
        end else if (cnt == 8'd0) begin
          if (state == S_P1) begin
            state_nxt = S_P2;
            cnt_nxt   = HOLD_LOAD;
          end else if (state == S_P2) begin
            state_nxt = S_P3;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
          if (abort_flag) begin
            aborted_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
            if (!dir && (occupancy != OCC_MAX)) begin
              occ_nxt = occupancy + OCC_ONE;
            end else if (dir && (occupancy != OCC_ZERO)) begin
              occ_nxt = occupancy - OCC_ONE;
            end
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase

    // Outputs are registered from the next state so each pattern appears
    // exactly when its state is entered and never changes mid-state.
    case (state_nxt)
      S_P1:    {a_nxt, b_nxt} = dir_nxt ? 2'b01 : 2'b10;
      S_P2:    {a_nxt, b_nxt} = 2'b11;
      S_P3:    {a_nxt, b_nxt} = dir_nxt ? 2'b10 : 2'b01;
      default: {a_nxt, b_nxt} = 2'b00;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      dir        <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      abort_flag <= abort_flag_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sensor_a  <= 1'b0;
      sensor_b  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cmd_ready <= 1'b1;
      occupancy <= OCC_ZERO;
    end else begin
      sensor_a  <= a_nxt;
      sensor_b  <= b_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      aborted   <= aborted_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_car_sensor_driver.sv
// Bench for car_sensor_driver: a cycle-count model of the car waveform is
// compared against two instances (OCC_WIDTH 8 and 2) every cycle, plus
// hand-computed literal checks at key cycles of directed scenarios.
module tb_car_sensor_driver;
  localparam int H = 4;
  localparam int G = 4;
`ifdef CAR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk, reset, cmd_valid, cmd_dir, abort;
  logic       cmd_ready, sensor_a, sensor_b, busy, done, aborted;
  logic [7:0] occupancy;
  logic       s_cmd_ready, s_sensor_a, s_sensor_b, s_busy, s_done, s_aborted;
  logic [1:0] s_occupancy;

  int n_checks = 0;
  int n_errors = 0;

  car_sensor_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .OCC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .abort(abort), .sensor_a(sensor_a),
    .sensor_b(sensor_b), .busy(busy), .done(done), .aborted(aborted),
    .occupancy(occupancy)
  );

  car_sensor_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .OCC_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(s_cmd_ready), .abort(abort), .sensor_a(s_sensor_a),
    .sensor_b(s_sensor_b), .busy(s_busy), .done(s_done), .aborted(s_aborted),
    .occupancy(s_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: k counts cycles since the accept edge (0 = idle). The sequence
  // ends at cycle end_k: 3*H+G+1 normally, or abort cycle + G + 1.
  int         k = 0;
  int         end_k = 0;
  logic       mdir = 1'b0;
  logic       m_ab = 1'b0;
  logic       started = 1'b0;
  logic [1:0] exp_ab;
  logic       exp_busy, exp_ready, exp_done, exp_aborted;
  int         occ8 = 0;
  int         occ2 = 0;
  logic [1:0] pat_entry [3] = '{2'b10, 2'b11, 2'b01};
  logic [1:0] pat_exit  [3] = '{2'b01, 2'b11, 2'b10};

  always @(posedge clk) begin
    started = 1'b1;
    exp_done = 1'b0;
    exp_aborted = 1'b0;
    if (!reset) begin
      k = 0;
      occ8 = 0;
      occ2 = 0;
    end else if (k == 0) begin
      if (cmd_valid) begin
        k = 1;
        mdir = cmd_dir;
        m_ab = 1'b0;
        end_k = 3 * H + G + 1;
      end
    end else begin
      if (ABORT_EN && abort && !m_ab && k <= 3 * H) begin
        m_ab = 1'b1;
        end_k = k + G + 1;
      end
      k++;
      if (k == end_k) begin
        k = 0;
        if (m_ab) exp_aborted = 1'b1;
        else begin
          exp_done = 1'b1;
          if (!mdir) begin
            occ8 = (occ8 < 255) ? occ8 + 1 : occ8;
            occ2 = (occ2 < 3) ? occ2 + 1 : occ2;
          end else begin
            occ8 = (occ8 > 0) ? occ8 - 1 : 0;
            occ2 = (occ2 > 0) ? occ2 - 1 : 0;
          end
        end
      end
    end
    if (k == 0) begin
      exp_ab = 2'b00; exp_busy = 1'b0; exp_ready = 1'b1;
    end else if (k <= 3 * H && !m_ab) begin
      exp_ab = mdir ? pat_exit[(k - 1) / H] : pat_entry[(k - 1) / H];
      exp_busy = 1'b1; exp_ready = 1'b0;
    end else begin
      exp_ab = 2'b00; exp_busy = 1'b1; exp_ready = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [13:0] got, expv;
    logic [7:0]  got_s, exp_s;
    if (started) begin
      got  = {cmd_ready, sensor_a, sensor_b, busy, done, aborted, occupancy};
      expv = {exp_ready, exp_ab, exp_busy, exp_done, exp_aborted, 8'(occ8)};
      n_checks++;
      if (got !== expv) begin
        n_errors++;
        $display("FAIL model_w8 t=%0t got(rdy,a,b,busy,done,abt,occ)=%b exp=%b", $time, got, expv);
      end
      got_s = {s_cmd_ready, s_sensor_a, s_sensor_b, s_busy, s_done, s_aborted, s_occupancy};
      exp_s = {exp_ready, exp_ab, exp_busy, exp_done, exp_aborted, 2'(occ2)};
      n_checks++;
      if (got_s !== exp_s) begin
        n_errors++;
        $display("FAIL model_w2 t=%0t got(rdy,a,b,busy,done,abt,occ)=%b exp=%b", $time, got_s, exp_s);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command; returns 1ns into cycle 1 of the new sequence.
  task automatic send(input logic d);
    cmd_valid = 1'b1;
    cmd_dir = d;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
    tick(1);
    @(negedge clk);
    lit("rst_ready", int'(cmd_ready), 1);
    lit("rst_busy", int'(busy), 0);
    lit("rst_occ", int'(occupancy), 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // entry: 10 / 11 / 01 / 00, done at cycle 17
    send(1'b0);
    @(negedge clk); lit("ent_p1", int'({sensor_a, sensor_b}), 2);
    tick(4); @(negedge clk); lit("ent_p2", int'({sensor_a, sensor_b}), 3);
    tick(4); @(negedge clk); lit("ent_p3", int'({sensor_a, sensor_b}), 1);
    tick(4); @(negedge clk); lit("ent_gap", int'({sensor_a, sensor_b}), 0);
    lit("ent_gap_busy", int'(busy), 1);
    tick(4); @(negedge clk);
    lit("ent_done", int'(done), 1);
    lit("ent_done_busy", int'(busy), 0);
    lit("ent_done_ready", int'(cmd_ready), 1);
    lit("ent_occ", int'(occupancy), 1);

    // back-to-back second entry
    send(1'b0);
    tick(16); @(negedge clk); lit("ent2_occ", int'(occupancy), 2);

    // exit: 01 / 11 / 10, occupancy 2 -> 1
    send(1'b1);
    @(negedge clk); lit("ext_p1", int'({sensor_a, sensor_b}), 1);
    tick(4); @(negedge clk); lit("ext_p2", int'({sensor_a, sensor_b}), 3);
    tick(4); @(negedge clk); lit("ext_p3", int'({sensor_a, sensor_b}), 2);
    tick(8); @(negedge clk);
    lit("ext_done", int'(done), 1);
    lit("ext_occ", int'(occupancy), 1);

    // exit to 0, then exit at 0 saturates
    send(1'b1); tick(16);
    send(1'b1); tick(16); @(negedge clk);
    lit("ext0_done", int'(done), 1);
    lit("ext0_occ", int'(occupancy), 0);

    // five entries: narrow counter holds at 3
    repeat (5) begin
      send(1'b0);
      tick(16);
    end
    @(negedge clk);
    lit("five_occ8", int'(occupancy), 5);
    lit("five_occ2", int'(s_occupancy), 3);

    // cmd_valid held high: accepts at cycles 0, 17, 34 only
    cmd_valid = 1'b1; cmd_dir = 1'b0;
    tick(1);
    tick(16); @(negedge clk);
    lit("hold_c17_done", int'(done), 1);
    lit("hold_c17_busy", int'(busy), 0);
    tick(1); @(negedge clk);
    lit("hold_c18_busy", int'(busy), 1);
    lit("hold_c18_pat", int'({sensor_a, sensor_b}), 2);
    tick(16); @(negedge clk); lit("hold_c34_done", int'(done), 1);
    tick(1); @(negedge clk); lit("hold_c35_busy", int'(busy), 1);
    cmd_valid = 1'b0;
    tick(17); @(negedge clk);
    lit("hold_occ", int'(occupancy), 8);
    lit("hold_idle", int'(busy), 0);

    // reset during P2
    send(1'b0);
    tick(5);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    lit("mrst_busy", int'(busy), 0);
    lit("mrst_ready", int'(cmd_ready), 1);
    lit("mrst_pat", int'({sensor_a, sensor_b}), 0);
    lit("mrst_occ", int'(occupancy), 0);
    tick(1);
    send(1'b0);
    tick(16); @(negedge clk);
    lit("post_rst_done", int'(done), 1);
    lit("post_rst_occ", int'(occupancy), 1);

    // abort in cycle 6 of an entry
    send(1'b0);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
`ifdef CAR_ABORT_EN
    lit("abt_c7_pat", int'({sensor_a, sensor_b}), 0);
    lit("abt_c7_busy", int'(busy), 1);
    tick(4); @(negedge clk);
    lit("abt_c11_aborted", int'(aborted), 1);
    lit("abt_c11_done", int'(done), 0);
    lit("abt_c11_occ", int'(occupancy), 1);
`else
    lit("noabt_c7_pat", int'({sensor_a, sensor_b}), 3);
    tick(10); @(negedge clk);
    lit("noabt_done", int'(done), 1);
    lit("noabt_aborted", int'(aborted), 0);
    lit("noabt_occ", int'(occupancy), 2);
`endif

    // abort while idle and during GAP has no effect
    tick(2);
    abort = 1'b1;
    tick(2);
    abort = 1'b0;
    send(1'b1);
    tick(13);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2); @(negedge clk);
    lit("gap_abort_done", int'(done), 1);
    lit("gap_abort_aborted", int'(aborted), 0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
